// File: rtl/dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : dmem_arbiter
// Description : Shares the single-ported data memory between the core
//               load/store path (priority) and a debug/loader port. The debug
//               port uses idle core cycles. A starvation counter forces a
//               one-cycle core stall so that a debug request is always served.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk_i, reset_ni           : rising-edge clock, synchronous active-low reset
//   core_*_i / core_rdata_o   : core load/store request and load data
//   core_stall_o              : core holds PC and suppresses writeback
//   dbg_*_i                   : debug request, direction, address, data, size
//   dbg_gnt_o                 : debug transfer performed this cycle
//   dbg_rdata_o, dbg_rvalid_o : registered debug read data and valid pulse
//   mem_*_o / mem_rdata_i     : Mem_Data interface (combinational read)
// ============================================================================
module dmem_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk_i,
    input  logic              reset_ni,
    input  logic [ADDR_W-1:0] core_addr_i,
    input  logic [DATA_W-1:0] core_wdata_i,
    input  logic              core_rd_i,
    input  logic              core_wr_i,
    input  logic [2:0]        core_funct3_i,
    output logic [DATA_W-1:0] core_rdata_o,
    output logic              core_stall_o,
    input  logic              dbg_req_i,
    input  logic              dbg_we_i,
    input  logic [ADDR_W-1:0] dbg_addr_i,
    input  logic [DATA_W-1:0] dbg_wdata_i,
    input  logic [2:0]        dbg_funct3_i,
    output logic              dbg_gnt_o,
    output logic [DATA_W-1:0] dbg_rdata_o,
    output logic              dbg_rvalid_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    output logic              mem_read_o,
    output logic              mem_write_o,
    output logic [2:0]        mem_funct3_o,
    input  logic [DATA_W-1:0] mem_rdata_i
);

    typedef enum logic [0:0] {
        ST_CORE  = 1'b0,
        ST_FORCE = 1'b1
    } state_e;

    localparam logic [7:0] STARVE_LIM = 8'(STARVE_MAX);

    state_e            state_q, state_d;
    logic [7:0]        starve_cnt_q, starve_cnt_d;
    logic [DATA_W-1:0] dbg_rdata_q, dbg_rdata_d;
    logic              dbg_rvalid_q, dbg_rvalid_d;

    logic core_req;
    logic dbg_own;
    logic dbg_denied;

    assign core_req = core_rd_i | core_wr_i;

    // Debug owns the memory in an idle core slot, or unconditionally in the
    // forced-stall cycle. A withdrawn request in FORCE hands it back to the core.
    assign dbg_own    = dbg_req_i & ((state_q == ST_FORCE) | ~core_req);
    assign dbg_denied = dbg_req_i & ~dbg_own;

    // Datapath mux; control strobes are gated by reset so an access in flight
    // when reset is asserted never commits.
    always_comb begin
        mem_addr_o   = dbg_own ? dbg_addr_i   : core_addr_i;
        mem_wdata_o  = dbg_own ? dbg_wdata_i  : core_wdata_i;
        mem_funct3_o = dbg_own ? dbg_funct3_i : core_funct3_i;
        mem_read_o   = reset_ni & (dbg_own ? ~dbg_we_i : core_rd_i);
        mem_write_o  = reset_ni & (dbg_own ?  dbg_we_i : core_wr_i);
        dbg_gnt_o    = reset_ni & dbg_own;
        core_stall_o = reset_ni & (state_q == ST_FORCE) & dbg_req_i;
    end

    assign core_rdata_o = mem_rdata_i;
    assign dbg_rdata_o  = dbg_rdata_q;
    assign dbg_rvalid_o = dbg_rvalid_q;

    // Next-state logic: FORCE always lasts one cycle, and the counter restarts
    // from zero on entry so forced stalls can never be back to back.
    always_comb begin
        state_d      = ST_CORE;
        starve_cnt_d = '0;
        dbg_rdata_d  = dbg_rdata_q;
        dbg_rvalid_d = 1'b0;
        if (state_q == ST_CORE && dbg_denied) begin
            if (starve_cnt_q + 8'd1 == STARVE_LIM) begin
                state_d = ST_FORCE;
            end else begin
                starve_cnt_d = starve_cnt_q + 8'd1;
            end
        end
        if (dbg_own && !dbg_we_i) begin
            dbg_rdata_d  = mem_rdata_i;
            dbg_rvalid_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!reset_ni) begin
            state_q      <= ST_CORE;
            starve_cnt_q <= '0;
            dbg_rdata_q  <= '0;
            dbg_rvalid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            starve_cnt_q <= starve_cnt_d;
            dbg_rdata_q  <= dbg_rdata_d;
            dbg_rvalid_q <= dbg_rvalid_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_dmem_arbiter
// Description : Directed self-checking bench for dmem_arbiter with a
//               byte-addressed data memory model (combinational read,
//               write on rising edge).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dmem_arbiter;

    localparam int ADDR_W     = 32;
    localparam int DATA_W     = 32;
    localparam int STARVE_MAX = 4;

    logic              clk = 1'b0;
    logic              reset_n;
    logic [ADDR_W-1:0] core_addr;
    logic [DATA_W-1:0] core_wdata;
    logic              core_rd, core_wr;
    logic [2:0]        core_funct3;
    logic [DATA_W-1:0] core_rdata;
    logic              core_stall;
    logic              dbg_req, dbg_we;
    logic [ADDR_W-1:0] dbg_addr;
    logic [DATA_W-1:0] dbg_wdata;
    logic [2:0]        dbg_funct3;
    logic              dbg_gnt;
    logic [DATA_W-1:0] dbg_rdata;
    logic              dbg_rvalid;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_read, mem_write;
    logic [2:0]        mem_funct3;
    logic [DATA_W-1:0] mem_rdata;

    logic [7:0] mem [0:63];

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    dmem_arbiter #(
        .ADDR_W    (ADDR_W),
        .DATA_W    (DATA_W),
        .STARVE_MAX(STARVE_MAX)
    ) u_dut (
        .clk_i        (clk),
        .reset_ni     (reset_n),
        .core_addr_i  (core_addr),
        .core_wdata_i (core_wdata),
        .core_rd_i    (core_rd),
        .core_wr_i    (core_wr),
        .core_funct3_i(core_funct3),
        .core_rdata_o (core_rdata),
        .core_stall_o (core_stall),
        .dbg_req_i    (dbg_req),
        .dbg_we_i     (dbg_we),
        .dbg_addr_i   (dbg_addr),
        .dbg_wdata_i  (dbg_wdata),
        .dbg_funct3_i (dbg_funct3),
        .dbg_gnt_o    (dbg_gnt),
        .dbg_rdata_o  (dbg_rdata),
        .dbg_rvalid_o (dbg_rvalid),
        .mem_addr_o   (mem_addr),
        .mem_wdata_o  (mem_wdata),
        .mem_read_o   (mem_read),
        .mem_write_o  (mem_write),
        .mem_funct3_o (mem_funct3),
        .mem_rdata_i  (mem_rdata)
    );

    // Memory model: little-endian bytes, 64-byte window.
    always_comb begin
        logic [5:0]  a;
        logic [31:0] w;
        a = mem_addr[5:0];
        w = {mem[a + 6'd3], mem[a + 6'd2], mem[a + 6'd1], mem[a]};
        case (mem_funct3)
            3'b000:  mem_rdata = {{24{w[7]}}, w[7:0]};
            3'b001:  mem_rdata = {{16{w[15]}}, w[15:0]};
            3'b100:  mem_rdata = {24'd0, w[7:0]};
            3'b101:  mem_rdata = {16'd0, w[15:0]};
            default: mem_rdata = w;
        endcase
    end

    always @(posedge clk) begin
        if (mem_write) begin
            mem[mem_addr[5:0]] <= mem_wdata[7:0];
            if (mem_funct3[1:0] != 2'b00)
                mem[mem_addr[5:0] + 6'd1] <= mem_wdata[15:8];
            if (mem_funct3[1:0] == 2'b10) begin
                mem[mem_addr[5:0] + 6'd2] <= mem_wdata[23:16];
                mem[mem_addr[5:0] + 6'd3] <= mem_wdata[31:24];
            end
        end
    end

    function automatic logic [31:0] mword(input logic [5:0] a);
        return {mem[a + 6'd3], mem[a + 6'd2], mem[a + 6'd1], mem[a]};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    endtask

    task automatic core_set(input logic rd, input logic wr, input logic [31:0] a,
                            input logic [31:0] d);
        core_rd = rd; core_wr = wr; core_addr = a; core_wdata = d; core_funct3 = 3'b010;
    endtask

    task automatic dbg_set(input logic req, input logic we, input logic [31:0] a,
                           input logic [31:0] d);
        dbg_req = req; dbg_we = we; dbg_addr = a; dbg_wdata = d; dbg_funct3 = 3'b010;
    endtask

    // Inputs change on the falling edge; combinational checks follow 1 ns later.
    task automatic half;
        @(negedge clk);
    endtask

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = 8'(i);
        reset_n = 1'b0;
        core_set(1'b0, 1'b1, 32'h20, 32'h1111_1111);
        dbg_set(1'b1, 1'b1, 32'h0C, 32'h2222_2222);

        // Reset with every request active.
        half; #1;
        chk("rst_mem_write", 32'(mem_write), 32'd0);
        chk("rst_mem_read", 32'(mem_read), 32'd0);
        chk("rst_dbg_gnt", 32'(dbg_gnt), 32'd0);
        chk("rst_core_stall", 32'(core_stall), 32'd0);
        half; #1;
        chk("rst_rvalid", 32'(dbg_rvalid), 32'd0);
        chk("rst_rdata", dbg_rdata, 32'd0);
        chk("rst_no_core_write", mword(6'h20), 32'h2322_2120);
        chk("rst_no_dbg_write", mword(6'h0C), 32'h0F0E_0D0C);

        // Idle-slot debug write.
        half; reset_n = 1'b1;
        core_set(1'b0, 1'b0, 32'h0, 32'h0);
        dbg_set(1'b1, 1'b1, 32'h0C, 32'hDEAD_BEEF);
        #1;
        chk("dw_gnt", 32'(dbg_gnt), 32'd1);
        chk("dw_stall", 32'(core_stall), 32'd0);
        chk("dw_mem_write", 32'(mem_write), 32'd1);

        // Debug read of the same word.
        half;
        dbg_set(1'b1, 1'b0, 32'h0C, 32'h0);
        #1;
        chk("dw_mem_word", mword(6'h0C), 32'hDEAD_BEEF);
        chk("dw_no_rvalid", 32'(dbg_rvalid), 32'd0);
        chk("dr_gnt", 32'(dbg_gnt), 32'd1);
        chk("dr_mem_read", 32'(mem_read), 32'd1);
        half;
        dbg_set(1'b0, 1'b0, 32'h0, 32'h0);
        #1;
        chk("dr_rvalid", 32'(dbg_rvalid), 32'd1);
        chk("dr_rdata", dbg_rdata, 32'hDEAD_BEEF);
        half; #1;
        chk("dr_rvalid_drop", 32'(dbg_rvalid), 32'd0);
        chk("dr_rdata_hold", dbg_rdata, 32'hDEAD_BEEF);

        // Starvation: core stores every cycle, debug reads 0x10.
        for (int c = 1; c <= STARVE_MAX; c++) begin
            half;
            core_set(1'b0, 1'b1, 32'h20, 32'h0000_1000 + 32'(c));
            dbg_set(1'b1, 1'b0, 32'h10, 32'h0);
            #1;
            chk($sformatf("st_gnt_c%0d", c), 32'(dbg_gnt), 32'd0);
            chk($sformatf("st_stall_c%0d", c), 32'(core_stall), 32'd0);
        end
        half;
        core_set(1'b0, 1'b1, 32'h20, 32'hBAD0_0005);
        #1;
        chk("st_force_stall", 32'(core_stall), 32'd1);
        chk("st_force_gnt", 32'(dbg_gnt), 32'd1);
        chk("st_force_mem_write", 32'(mem_write), 32'd0);
        chk("st_force_addr", mem_addr, 32'h10);
        half;
        dbg_set(1'b0, 1'b0, 32'h0, 32'h0);
        #1;
        chk("st_store_suppressed", mword(6'h20), 32'h0000_1004);
        chk("st_c6_stall", 32'(core_stall), 32'd0);
        chk("st_c6_mem_write", 32'(mem_write), 32'd1);
        chk("st_rvalid", 32'(dbg_rvalid), 32'd1);
        chk("st_rdata", dbg_rdata, 32'h1312_1110);
        half; #1;
        chk("st_store_done", mword(6'h20), 32'hBAD0_0005);

        // Withdrawal in FORCE.
        for (int c = 1; c <= STARVE_MAX; c++) begin
            half;
            core_set(1'b0, 1'b1, 32'h24, 32'h0000_2000 + 32'(c));
            dbg_set(1'b1, 1'b0, 32'h10, 32'h0);
        end
        half;
        core_set(1'b0, 1'b1, 32'h24, 32'h0000_2005);
        dbg_set(1'b0, 1'b0, 32'h10, 32'h0);
        #1;
        chk("wd_stall", 32'(core_stall), 32'd0);
        chk("wd_gnt", 32'(dbg_gnt), 32'd0);
        chk("wd_mem_write", 32'(mem_write), 32'd1);
        chk("wd_addr", mem_addr, 32'h24);
        // Back in CORE with a cleared counter: STARVE_MAX more denials needed.
        for (int c = 1; c <= STARVE_MAX; c++) begin
            half;
            core_set(1'b0, 1'b1, 32'h24, 32'h0000_3000 + 32'(c));
            dbg_set(1'b1, 1'b0, 32'h10, 32'h0);
            #1;
            chk($sformatf("wd_deny_c%0d", c), 32'(dbg_gnt), 32'd0);
        end
        chk("wd_store_done", mword(6'h24), 32'h0000_3003);
        half; #1;
        chk("wd_force_gnt", 32'(dbg_gnt), 32'd1);
        chk("wd_force_stall", 32'(core_stall), 32'd1);

        // Mid-transfer reset in a FORCE cycle with a debug write granted.
        half;
        dbg_set(1'b0, 1'b0, 32'h0, 32'h0);
        core_set(1'b0, 1'b0, 32'h0, 32'h0);
        for (int c = 1; c <= STARVE_MAX; c++) begin
            half;
            core_set(1'b0, 1'b1, 32'h28, 32'h0000_4000 + 32'(c));
            dbg_set(1'b1, 1'b1, 32'h30, 32'hCAFE_F00D);
        end
        half;
        reset_n = 1'b0;
        #1;
        chk("mr_gnt", 32'(dbg_gnt), 32'd0);
        chk("mr_stall", 32'(core_stall), 32'd0);
        chk("mr_mem_write", 32'(mem_write), 32'd0);
        half;
        reset_n = 1'b1;
        core_set(1'b0, 1'b1, 32'h28, 32'h0000_5000);
        dbg_set(1'b1, 1'b1, 32'h30, 32'hCAFE_F00D);
        #1;
        chk("mr_no_write", mword(6'h30), 32'h3332_3130);
        chk("mr_rvalid", 32'(dbg_rvalid), 32'd0);
        chk("mr_state_core", 32'(dbg_gnt), 32'd0);
        chk("mr_no_stall", 32'(core_stall), 32'd0);

        half;
        dbg_set(1'b0, 1'b0, 32'h0, 32'h0);
        core_set(1'b0, 1'b0, 32'h0, 32'h0);
        half;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single-ported data memory (Mem_Data) between two requesters: the core load/store path and a debug/loader port.
- The core has priority. The debug port uses idle core cycles.
- A starvation counter forces a one-cycle core stall so the debug port is always guaranteed an access.
- Sits between Core_module and Mem_Data. Drives core_stall back to the core, which holds the PC and suppresses writeback.

Parameters:
ADDR_W, 32, address width of all ports
DATA_W, 32, data width of all ports
STARVE_MAX, 4, consecutive denied debug-request cycles before a forced stall (legal 1..255)

Ports:
clk  in  1  clock, rising edge
reset  in  1  synchronous, active-low reset
core_addr  in  ADDR_W  core effective address (ALU result)
core_wdata  in  DATA_W  core store data (rs2 value)
core_rd  in  1  core load request
core_wr  in  1  core store request
core_funct3  in  3  core access size/sign
core_rdata  out  DATA_W  load data to core
core_stall  out  1  core must hold PC and suppress writeback this cycle
dbg_req  in  1  debug access request
dbg_we  in  1  1 = write, 0 = read
dbg_addr  in  ADDR_W  debug address
dbg_wdata  in  DATA_W  debug write data
dbg_funct3  in  3  debug access size/sign
dbg_gnt  out  1  debug access performed this cycle
dbg_rdata  out  DATA_W  registered debug read data
dbg_rvalid  out  1  one-cycle pulse: dbg_rdata valid
mem_addr  out  ADDR_W  to Mem_Data addr
mem_wdata  out  DATA_W  to Mem_Data write_data
mem_read  out  1  to Mem_Data mem_read
mem_write  out  1  to Mem_Data mem_write
mem_funct3  out  3  to Mem_Data funct_3
mem_rdata  in  DATA_W  from Mem_Data (combinational read)

Behaviour:
- Memory model: combinational read; write commits on the rising clk edge.
- Reset (reset=0 at a rising edge):
  - state=CORE, starve_cnt=0, dbg_rdata=0, dbg_rvalid=0.
  - While reset=0, dbg_gnt, core_stall, mem_read and mem_write are forced to 0 combinationally.
  - Reset mid-access aborts the access. No write occurs on that edge.
- Owner selection (combinational, per cycle):
  - State CORE, core_rd|core_wr=1: core owns memory. mem_* = core_*. dbg_gnt=0, core_stall=0.
  - State CORE, core idle, dbg_req=1: debug owns memory. mem_read=~dbg_we, mem_write=dbg_we. dbg_gnt=1.
  - State FORCE, dbg_req=1: debug owns memory. core_stall=1, dbg_gnt=1. Core rd/wr is ignored, so no core write reaches memory.
  - State FORCE, dbg_req=0 (request withdrawn): core_stall=0 and the core owns memory as in CORE.
  - No requester: mem_read=mem_write=0. mem_addr/wdata/funct3 follow core_*.
- core_rdata = mem_rdata always. It is only meaningful when the core owns memory and core_stall=0.
- Starvation counter:
  - Each cycle with dbg_req=1 and dbg_gnt=0: starve_cnt+1.
  - Any cycle with dbg_gnt=1 or dbg_req=0: starve_cnt=0.
  - When a denied cycle would make starve_cnt reach STARVE_MAX, next state=FORCE and starve_cnt=0.
- FSM transitions:
  - CORE->FORCE per the starvation counter rule.
  - FORCE->CORE unconditionally after one cycle, so FORCE lasts exactly one cycle.
  - Back-to-back stalls are impossible: the counter restarts from 0.
- Debug handshake:
  - Requester holds dbg_req, dbg_we, dbg_addr, dbg_wdata and dbg_funct3 stable until it samples dbg_gnt=1 at a rising edge.
  - One grant equals one transfer. Keeping dbg_req high after a grant presents the next transfer.
- Debug read return:
  - On a granted debug read, mem_rdata is captured into dbg_rdata at that edge.
  - dbg_rvalid=1 for exactly the following cycle. dbg_rdata holds until the next granted read.
  - Debug writes do not pulse dbg_rvalid.
- Worst-case debug latency: STARVE_MAX+1 cycles from dbg_req rising to dbg_gnt.
- Simultaneous core and debug access with the counter below threshold: the core wins and the counter increments.

Test Plan:
- Reset: hold reset=0 for 2 cycles with all requests active -> mem_write=0, dbg_gnt=0, core_stall=0, dbg_rvalid=0, dbg_rdata=0.
- Idle-slot debug write:
  - Stimulus: core idle; dbg_req=1, dbg_we=1, dbg_addr=0x0C, dbg_wdata=0xDEADBEEF, funct3=010.
  - Response: dbg_gnt=1 in the same cycle; memory[15:12]=DE AD BE EF after the edge; no stall.
- Debug read return: core idle; debug read of 0x0C, funct3=010 -> dbg_gnt=1; next cycle dbg_rvalid=1 and dbg_rdata=0xDEADBEEF; dbg_rvalid=0 the cycle after.
- Starvation, STARVE_MAX=4:
  - Stimulus: core issues sw every cycle; dbg_req=1 (read 0x10).
  - Response: dbg_gnt=0 for cycles 1-4. Cycle 5: core_stall=1, dbg_gnt=1, core store suppressed (memory at core address unchanged). Cycle 6: core_stall=0 and the core store proceeds.
- Withdrawal in FORCE: starve the debug port to threshold, then drop dbg_req in the FORCE cycle -> core_stall=0, core access proceeds, state returns to CORE, starve_cnt=0.
- Mid-transfer reset: assert reset=0 in the cycle a debug write is granted -> no write to memory; state CORE; dbg_rvalid stays 0.
